// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for load-use, taken-branch and multi-cycle Execute hazards
module pipe_hazard_ctrl #(
  parameter int REGW   = 4,
  parameter int MC_LAT = 4,
  parameter int PERFW  = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [REGW-1:0]  RA1D,
  input  logic [REGW-1:0]  RA2D,
  input  logic             RA1VD,
  input  logic             RA2VD,
  input  logic [REGW-1:0]  WA3E,
  input  logic             RegWriteE,
  input  logic             MemtoRegE,
  input  logic             MultiE,
  input  logic             BranchTakenE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             BusyE,
  output logic             DoneE,
  output logic [PERFW-1:0] StallCycles
);
  localparam int CW = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((MC_LAT > 1) ? MC_LAT - 2 : 0);
  typedef enum logic {RUN = 1'b0, MCWAIT = 1'b1} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic ldhaz, multi;
  assign ldhaz = MemtoRegE & RegWriteE & ((RA1VD & (RA1D == WA3E)) | (RA2VD & (RA2D == WA3E)));
  assign multi = MultiE && (MC_LAT > 1);
  // state and remaining-cycle counter; reset aborts any operation in flight
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end
  // hazard priority: reset, multi-cycle hold, multi-cycle completion, branch redirect, load-use
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    StallF  = 1'b0;
    StallD  = 1'b0;
    StallE  = 1'b0;
    FlushD  = 1'b0;
    FlushE  = 1'b0;
    FlushM  = 1'b0;
    BusyE   = 1'b0;
    DoneE   = 1'b0;
    if (RST) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushM = 1'b1;
    end else if (state == MCWAIT && cnt != '0) begin
      {StallF, StallD, StallE, FlushM, BusyE} = '1;
      cnt_n = cnt - CW'(1);
    end else if (state == MCWAIT) begin
      BusyE   = 1'b1;
      DoneE   = 1'b1;
      FlushD  = BranchTakenE;
      FlushE  = BranchTakenE;
      state_n = RUN;
    end else if (multi) begin
      {StallF, StallD, StallE, FlushM, BusyE} = '1;
      state_n = MCWAIT;
      cnt_n   = CNT_INIT;
    end else if (BranchTakenE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (ldhaz) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end
  // saturating count of Decode-stall cycles
  always_ff @(posedge CLK) begin
    if (RST) StallCycles <= '0;
    else if (StallD && !(&StallCycles)) StallCycles <= StallCycles + PERFW'(1);
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and random checks of two configurations against a cycle-level reference model
module tb_pipe_hazard_ctrl;
  logic CLK, RST, RA1VD, RA2VD, RegWriteE, MemtoRegE, MultiE, BranchTakenE;
  logic [3:0] RA1D, RA2D, WA3E;
  wire [7:0] o0, o1;
  wire [3:0] sc0;
  wire [15:0] sc1;
  int total = 0, bad = 0;
  int p0, p1, pc0, pc1;
  pipe_hazard_ctrl #(.REGW(4), .MC_LAT(4), .PERFW(4)) u0 (
    .CLK(CLK), .RST(RST), .RA1D(RA1D), .RA2D(RA2D), .RA1VD(RA1VD), .RA2VD(RA2VD),
    .WA3E(WA3E), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MultiE(MultiE),
    .BranchTakenE(BranchTakenE), .StallF(o0[7]), .StallD(o0[6]), .StallE(o0[5]),
    .FlushD(o0[4]), .FlushE(o0[3]), .FlushM(o0[2]), .BusyE(o0[1]), .DoneE(o0[0]),
    .StallCycles(sc0));
  pipe_hazard_ctrl #(.REGW(4), .MC_LAT(1), .PERFW(16)) u1 (
    .CLK(CLK), .RST(RST), .RA1D(RA1D), .RA2D(RA2D), .RA1VD(RA1VD), .RA2VD(RA2VD),
    .WA3E(WA3E), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MultiE(MultiE),
    .BranchTakenE(BranchTakenE), .StallF(o1[7]), .StallD(o1[6]), .StallE(o1[5]),
    .FlushD(o1[4]), .FlushE(o1[3]), .FlushM(o1[2]), .BusyE(o1[1]), .DoneE(o1[0]),
    .StallCycles(sc1));
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask
  // p = cycles already spent in the current multi-cycle op (0 = none); bits {SF,SD,SE,FD,FE,FM,BUSY,DONE}
  function automatic logic [7:0] ref_out(int L, int p);
    logic ld = MemtoRegE & RegWriteE & ((RA1VD & (RA1D == WA3E)) | (RA2VD & (RA2D == WA3E)));
    if (RST) return 8'b0001_1100;
    if (p > 0 && p < L - 1) return 8'b1110_0110;
    if (p > 0) return {3'b000, BranchTakenE, BranchTakenE, 3'b011};
    if (MultiE && L > 1) return 8'b1110_0110;
    if (BranchTakenE) return 8'b0001_1000;
    if (ld) return 8'b1100_1000;
    return 8'b0;
  endfunction
  function automatic int nxt(int L, int p);
    if (RST) return 0;
    if (p > 0 && p < L - 1) return p + 1;
    if (p > 0) return 0;
    return (MultiE && L > 1) ? 1 : 0;
  endfunction
  task automatic setin(input logic r, input logic [3:0] a1, input logic [3:0] a2, input logic v1,
                       input logic v2, input logic [3:0] wa, input logic rw, input logic m2r,
                       input logic mul, input logic br);
    RST = r; RA1D = a1; RA2D = a2; RA1VD = v1; RA2VD = v2; WA3E = wa;
    RegWriteE = rw; MemtoRegE = m2r; MultiE = mul; BranchTakenE = br;
  endtask
  task automatic cyc();
    logic [7:0] e0, e1;
    #2;
    e0 = ref_out(4, p0);
    e1 = ref_out(1, p1);
    chk("ctl_lat4", {24'b0, o0}, {24'b0, e0});
    chk("perf_lat4", {28'b0, sc0}, pc0);
    chk("ctl_lat1", {24'b0, o1}, {24'b0, e1});
    chk("perf_lat1", {16'b0, sc1}, pc1);
    @(posedge CLK);
    pc0 = RST ? 0 : (e0[6] && pc0 < 15) ? pc0 + 1 : pc0;
    pc1 = RST ? 0 : (e1[6] && pc1 < 65535) ? pc1 + 1 : pc1;
    p0 = nxt(4, p0);
    p1 = nxt(1, p1);
    #1;
  endtask
  initial begin
    setin(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge CLK);
    #1;
    p0 = 0; p1 = 0; pc0 = 0; pc1 = 0;
    cyc();
    setin(0, 5, 0, 1, 0, 5, 1, 1, 0, 0); cyc();
    chk("ldhaz_perf", {28'b0, sc0}, 1);
    RA1VD = 0; cyc();
    RA2D = 5; RA2VD = 1; cyc();
    setin(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); cyc();
    MultiE = 0; RST = 0; MultiE = 1;
    repeat (4) cyc();
    MultiE = 0; cyc();
    chk("mc_perf", {28'b0, sc0}, 3);
    setin(0, 5, 0, 1, 0, 5, 1, 1, 0, 1); cyc();
    setin(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); cyc(); cyc();
    BranchTakenE = 1; cyc(); cyc();
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cyc();
    MultiE = 1; cyc(); cyc();
    RST = 1; cyc();
    chk("rst_perf", {28'b0, sc0}, 0);
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cyc();
    setin(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); cyc();
    setin(0, 7, 7, 1, 1, 7, 1, 1, 0, 0);
    repeat (20) cyc();
    chk("sat_perf", {28'b0, sc0}, 15);
    for (int i = 0; i < 600; i++) begin
      setin($urandom_range(0, 24) == 0, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), 4'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
            $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0);
      cyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Stall/flush sequencer for the 5-stage pipeline (Fetch, Decode, Execute, Memory, Writeback).
- Drives the stall and clear inputs of the F/D, D/E and E/M pipeline registers.
- Detects load-use hazards and applies taken-branch flushes.
- Holds the pipeline while a multi-cycle Execute operation runs, and keeps a saturating stall-cycle performance counter.

Parameters:
REGW, 4, register-address width
MC_LAT, 4, total Execute cycles of a multi-cycle operation (>=1)
PERFW, 16, width of the stall-cycle performance counter

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  synchronous reset, active-high
RA1D  in  REGW  source register 1 of the Decode instruction
RA2D  in  REGW  source register 2 of the Decode instruction
RA1VD  in  1  RA1D is actually read
RA2VD  in  1  RA2D is actually read
WA3E  in  REGW  destination register of the Execute instruction
RegWriteE  in  1  Execute instruction writes a register
MemtoRegE  in  1  Execute instruction is a load
MultiE  in  1  Execute instruction is a multi-cycle operation
BranchTakenE  in  1  branch resolved taken in Execute
StallF  out  1  hold the PC
StallD  out  1  hold the F/D register
StallE  out  1  hold the D/E register
FlushD  out  1  clear the F/D register
FlushE  out  1  clear the D/E register
FlushM  out  1  clear the E/M register (bubble)
BusyE  out  1  multi-cycle operation in progress
DoneE  out  1  final cycle of a multi-cycle operation
StallCycles  out  PERFW  count of cycles with StallD=1

Behaviour:
- State: FSM {RUN, MCWAIT}; down-counter cnt, width max(1, ceil(log2(MC_LAT))); perf counter.
- All outputs except StallCycles are combinational from the current state and inputs.
- RST=1 (synchronous, takes effect at the edge):
  - Next cycle: state=RUN, cnt=0, StallCycles=0.
  - While RST is high: FlushD=FlushE=FlushM=1; StallF=StallD=StallE=0; BusyE=DoneE=0.
  - Reset during MCWAIT aborts the operation; there is no DoneE pulse.
- Load-use hazard, ldhaz = MemtoRegE & RegWriteE & ((RA1VD & RA1D==WA3E) | (RA2VD & RA2D==WA3E)).
- RUN with ldhaz=1 and MultiE=0:
  - StallF=StallD=1 and FlushE=1 for exactly one cycle.
  - The load moves to Memory; the next cycle re-evaluates with a bubble in Execute.
- RUN with MultiE=1 and MC_LAT>1:
  - This is cycle 1 of the operation.
  - StallF=StallD=StallE=1, FlushM=1, BusyE=1.
  - Next state=MCWAIT, cnt=MC_LAT-2.
- MCWAIT:
  - StallF=StallD=StallE=1, FlushM=1, BusyE=1.
  - cnt decrements each cycle while cnt>0.
  - When cnt==0: all stalls and FlushM are 0, BusyE=1, DoneE=1; the instruction advances at that edge and the next state is RUN.
  - Total stall cycles = MC_LAT-1, with MultiE held by the stalled D/E register.
  - No retrigger on the same instruction: DoneE is only raised from MCWAIT.
- MC_LAT==1: MultiE has no effect; BusyE and DoneE stay 0.
- BranchTakenE:
  - Honoured only when StallE=0, i.e. in RUN with MultiE=0, or in the MCWAIT cycle with cnt==0.
  - Effect: FlushD=1 and FlushE=1 that cycle; StallF=StallD=0 (the redirect wins over ldhaz).
  - A branch that is also multi-cycle flushes on its DoneE cycle.
- Simultaneous ldhaz and MultiE in RUN: the multi-cycle sequence wins. The load-use check re-runs after DoneE because the Decode instruction is still held.
- StallCycles: +1 on each edge where StallD=1 and RST=0; saturates at all-ones with no wrap.
- Forwarding is not this block's job; it only generates stalls, flushes and bubbles.

Test Plan:
- Load-use: RST 1 cycle, then MemtoRegE=RegWriteE=1, WA3E=5, RA1D=5, RA1VD=1 -> StallF=StallD=FlushE=1 for one cycle; with RA1VD=0 instead -> no stall.
- Multi-cycle, MC_LAT=4: MultiE=1 in RUN -> StallF/D/E=FlushM=BusyE=1 for 3 cycles, then DoneE=1 with stalls 0 on cycle 4; back in RUN on cycle 5; StallCycles=3.
- Branch: BranchTakenE=1 in RUN with ldhaz=1 -> FlushD=FlushE=1, StallF=StallD=0; BranchTakenE=1 during MCWAIT with cnt=1 -> ignored; flush occurs on the DoneE cycle.
- Reset mid-operation: assert RST in cycle 2 of a MC_LAT=4 operation -> next cycle state=RUN, BusyE=0, no DoneE, StallCycles=0, flushes 1 while RST is high.
- Saturation, PERFW=4: hold a load-use hazard for 20 cycles -> StallCycles reaches 15 and stays there.
- MC_LAT=1 with MultiE=1 -> no stall, BusyE=DoneE=0.
